tx_resp_arbiter: RTL and testbench

Shares the single UART transmit path between two response sources in the REF_CLK domain: register-file read data (one byte) and ALU results (16 bits, sent as two bytes, LSB first). Each source gets a one-entry holding buffer with a valid/ready handshake. When both buffers hold data, a round-robin arbiter picks which goes next. The block drives the TX data bus and a level valid toward the TX-domain data synchronizer, and paces transfers with the synchronized TX busy flag. It retries a byte if busy is never acknowledged.

---
 rtl/tx_resp_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_tx_resp_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_resp_arbiter.sv
// Shares the REF_CLK-domain UART TX byte path between a one-byte register-read source and a
// two-byte ALU source, with round-robin arbitration on ties and a busy-timeout retry.
module tx_resp_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ALU_WIDTH  = 16,
    parameter int unsigned TIMEOUT    = 200
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_rd_valid,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_rd_ready,
    input  logic                  i_alu_valid,
    input  logic [ALU_WIDTH-1:0]  i_alu_data,
    output logic                  o_alu_ready,
    input  logic                  i_busy,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_valid,
    output logic                  o_active,
    output logic                  o_timeout
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDrain,
        StRetry
    } state_e;

    localparam int unsigned TimerWidth = 8;
    localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TIMEOUT - 1);
    localparam logic SrcRd  = 1'b0;
    localparam logic SrcAlu = 1'b1;

    // Holding buffers
    logic                  r_rd_full;
    logic [DATA_WIDTH-1:0] r_rd_buf;
    logic                  r_alu_full;
    logic [ALU_WIDTH-1:0]  r_alu_buf;

    // Transmit FSM state
    state_e                r_state;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_valid;
    logic                  r_timeout;
    logic [TimerWidth-1:0] r_timer;
    logic                  r_last_grant;
    logic                  r_grant;
    logic                  r_msb_sent;

    state_e                w_state_nxt;
    logic [DATA_WIDTH-1:0] w_tx_data_nxt;
    logic                  w_tx_valid_nxt;
    logic                  w_timeout_nxt;
    logic [TimerWidth-1:0] w_timer_nxt;
    logic                  w_last_grant_nxt;
    logic                  w_grant_nxt;
    logic                  w_msb_sent_nxt;

    logic w_rd_accept;
    logic w_alu_accept;
    logic w_rd_free;
    logic w_alu_free;
    logic w_any_full;
    logic w_pick_alu;

    assign w_rd_accept  = i_rd_valid & ~r_rd_full;
    assign w_alu_accept = i_alu_valid & ~r_alu_full;

    assign o_rd_ready  = ~r_rd_full;
    assign o_alu_ready = ~r_alu_full;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rd_full  <= 1'b0;
            r_rd_buf   <= '0;
            r_alu_full <= 1'b0;
            r_alu_buf  <= '0;
        end else begin
            // A buffer is freed only at the end of its own frame, so accept and free are exclusive.
            if (w_rd_accept) begin
                r_rd_full <= 1'b1;
                r_rd_buf  <= i_rd_data;
            end else if (w_rd_free) begin
                r_rd_full <= 1'b0;
            end
            if (w_alu_accept) begin
                r_alu_full <= 1'b1;
                r_alu_buf  <= i_alu_data;
            end else if (w_alu_free) begin
                r_alu_full <= 1'b0;
            end
        end
    end

    // On a tie the source that did not win last time goes next.
    assign w_any_full = r_rd_full | r_alu_full;
    assign w_pick_alu = (r_rd_full & r_alu_full) ? (r_last_grant == SrcRd) : r_alu_full;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= StIdle;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_timeout    <= 1'b0;
            r_timer      <= '0;
            r_last_grant <= SrcAlu;
            r_grant      <= SrcRd;
            r_msb_sent   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_tx_valid   <= w_tx_valid_nxt;
            r_timeout    <= w_timeout_nxt;
            r_timer      <= w_timer_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_grant      <= w_grant_nxt;
            r_msb_sent   <= w_msb_sent_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_tx_data_nxt    = r_tx_data;
        w_tx_valid_nxt   = r_tx_valid;
        w_timeout_nxt    = 1'b0;
        w_timer_nxt      = r_timer;
        w_last_grant_nxt = r_last_grant;
        w_grant_nxt      = r_grant;
        w_msb_sent_nxt   = r_msb_sent;
        w_rd_free        = 1'b0;
        w_alu_free       = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_any_full) begin
                    w_grant_nxt      = w_pick_alu;
                    w_last_grant_nxt = w_pick_alu;
                    w_msb_sent_nxt   = 1'b0;
                    w_tx_data_nxt    = w_pick_alu ? r_alu_buf[DATA_WIDTH-1:0] : r_rd_buf;
                    w_tx_valid_nxt   = 1'b1;
                    w_timer_nxt      = '0;
                    w_state_nxt      = StReq;
                end
            end
            StReq: begin
                // Busy already high on entry still counts as the acknowledge.
                if (i_busy) begin
                    w_tx_valid_nxt = 1'b0;
                    w_state_nxt    = StDrain;
                end else if (r_timer == TimerLast) begin
                    w_tx_valid_nxt = 1'b0;
                    w_timeout_nxt  = 1'b1;
                    w_state_nxt    = StRetry;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            StRetry: begin
                w_tx_valid_nxt = 1'b1;
                w_timer_nxt    = '0;
                w_state_nxt    = StReq;
            end
            StDrain: begin
                if (!i_busy) begin
                    if ((r_grant == SrcAlu) && !r_msb_sent) begin
                        w_tx_data_nxt  = r_alu_buf[ALU_WIDTH-1:DATA_WIDTH];
                        w_msb_sent_nxt = 1'b1;
                        w_tx_valid_nxt = 1'b1;
                        w_timer_nxt    = '0;
                        w_state_nxt    = StReq;
                    end else begin
                        w_rd_free   = (r_grant == SrcRd);
                        w_alu_free  = (r_grant == SrcAlu);
                        w_state_nxt = StIdle;
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;
    assign o_timeout  = r_timeout;
    assign o_active   = (r_state != StIdle);

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// Randomized self-checking bench for tx_resp_arbiter: a source-level scoreboard predicts the
// byte order and a behavioural TX responder checks valid/busy/timeout timing.
module tb_tx_resp_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 16;
    localparam int unsigned TO = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          i_rd_valid = 1'b0;
    logic [DW-1:0] i_rd_data = '0;
    logic          o_rd_ready;
    logic          i_alu_valid = 1'b0;
    logic [AW-1:0] i_alu_data = '0;
    logic          o_alu_ready;
    logic          i_busy = 1'b0;
    logic [DW-1:0] o_tx_data;
    logic          o_tx_valid;
    logic          o_active;
    logic          o_timeout;

    tx_resp_arbiter #(
        .DATA_WIDTH(DW),
        .ALU_WIDTH (AW),
        .TIMEOUT   (TO)
    ) u_dut (
        .CLK        (CLK),
        .RST        (RST),
        .i_rd_valid (i_rd_valid),
        .i_rd_data  (i_rd_data),
        .o_rd_ready (o_rd_ready),
        .i_alu_valid(i_alu_valid),
        .i_alu_data (i_alu_data),
        .o_alu_ready(o_alu_ready),
        .i_busy     (i_busy),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .o_active   (o_active),
        .o_timeout  (o_timeout)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus queues and source-level model
    logic [7:0]  rd_q[$];
    logic [15:0] alu_q[$];
    int          gap_max = 0;
    bit          m_rd_full = 1'b0;
    bit          m_alu_full = 1'b0;
    bit          m_last_alu = 1'b1;
    logic [7:0]  m_rd_byte = '0;
    logic [15:0] m_alu_word = '0;
    logic [7:0]  frame_q[$];
    logic [7:0]  log_q[$];
    logic [7:0]  cur_byte = '0;
    bit          cur_src = 1'b0;
    bit          pend_rd = 1'b0;
    bit          pend_alu = 1'b0;
    logic [7:0]  pend_rd_byte = '0;
    logic [15:0] pend_alu_word = '0;

    // TX responder and observation state
    int resp_phase = 0;
    int resp_cnt = 0;
    int resp_w = 0;
    int resp_b = 1;
    int resp_bcnt = 0;
    bit resp_ack = 1'b1;
    bit fix_mode = 1'b1;
    int fix_to_left = 0;
    int fix_w = 0;
    int fix_b = 1;
    int cyc = 0;
    int hi_len = 0;
    bit retry_exp = 1'b0;
    bit prev_valid = 1'b0;
    bit prev_rd_ready = 1'b1;
    bit prev_alu_ready = 1'b1;
    int last_drop_cyc = 0;
    int rd_acc_cyc = 0;
    int frame_rise_cyc = 0;
    int n_timeouts = 0;
    int n_rd_acc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic start_frame();
        bit src;
        if (m_rd_full && m_alu_full) begin
            src = !m_last_alu;
        end else if (m_rd_full) begin
            src = 1'b0;
        end else if (m_alu_full) begin
            src = 1'b1;
        end else begin
            check("spurious_frame", 32'(o_tx_data), 32'hFFFF_FFFF);
            return;
        end
        m_last_alu     = src;
        cur_src        = src;
        frame_rise_cyc = cyc;
        if (!src) begin
            frame_q.push_back(m_rd_byte);
            m_rd_full = 1'b0;
        end else begin
            frame_q.push_back(m_alu_word[7:0]);
            frame_q.push_back(m_alu_word[15:8]);
            m_alu_full = 1'b0;
        end
    endtask

    task automatic resp_start();
        resp_phase = 1;
        resp_cnt   = 0;
        if (fix_mode) begin
            if (fix_to_left > 0) begin
                resp_ack = 1'b0;
                fix_to_left--;
            end else begin
                resp_ack = 1'b1;
            end
            resp_w = fix_w;
            resp_b = fix_b;
        end else begin
            resp_ack = ($urandom_range(0, 5) != 0);
            resp_w   = int'($urandom_range(0, TO - 1));
            resp_b   = int'($urandom_range(1, 4));
        end
    endtask

    task automatic observe();
        if (o_rd_ready && !prev_rd_ready) begin
            check("rd_free_src", 32'(!cur_src && frame_q.size() == 0), 32'd1);
            check("rd_free_time", cyc, last_drop_cyc + 1);
        end
        if (o_alu_ready && !prev_alu_ready) begin
            check("alu_free_src", 32'(cur_src && frame_q.size() == 0), 32'd1);
            check("alu_free_time", cyc, last_drop_cyc + 1);
        end
        if (o_timeout && !(prev_valid && !o_tx_valid)) begin
            check("timeout_stray", 32'(o_timeout), 32'd0);
        end
        if (o_tx_valid && !prev_valid) begin
            check("active", 32'(o_active), 32'd1);
            if (retry_exp) begin
                retry_exp = 1'b0;
                check("retry_data", 32'(o_tx_data), 32'(cur_byte));
            end else begin
                if (frame_q.size() == 0) start_frame();
                if (frame_q.size() != 0) begin
                    cur_byte = frame_q.pop_front();
                    log_q.push_back(cur_byte);
                end
                check("tx_data", 32'(o_tx_data), 32'(cur_byte));
            end
            hi_len = 1;
            resp_start();
        end else if (o_tx_valid) begin
            hi_len++;
            check("tx_stable", 32'(o_tx_data), 32'(cur_byte));
        end else if (prev_valid) begin
            if (o_timeout) begin
                n_timeouts++;
                check("timeout_unacked", 32'(resp_ack), 32'd0);
                check("timeout_len", hi_len, TO);
                retry_exp  = 1'b1;
                resp_phase = 0;
            end else begin
                check("fall_acked", 32'(resp_ack), 32'd1);
                check("fall_len", hi_len, resp_w + 1);
            end
        end else if (retry_exp) begin
            retry_exp = 1'b0;
            check("retry_gap", 32'(o_tx_valid), 32'd1);
        end
        prev_valid     = o_tx_valid;
        prev_rd_ready  = o_rd_ready;
        prev_alu_ready = o_alu_ready;
    endtask

    task automatic respond();
        if (resp_phase == 1) begin
            if (resp_ack && resp_cnt == resp_w) begin
                i_busy     = 1'b1;
                resp_bcnt  = resp_b;
                resp_phase = 2;
            end else begin
                resp_cnt++;
            end
        end else if (resp_phase == 2) begin
            resp_bcnt--;
            if (resp_bcnt == 0) begin
                i_busy        = 1'b0;
                last_drop_cyc = cyc;
                resp_phase    = 0;
            end
        end
    endtask

    task automatic cycle();
        @(negedge CLK);
        cyc++;
        observe();
        // Accepts sampled at the edge just passed become visible to the arbiter from now on.
        if (pend_rd) begin
            m_rd_full  = 1'b1;
            m_rd_byte  = pend_rd_byte;
            rd_acc_cyc = cyc;
            n_rd_acc++;
            check("rd_ready_drop", 32'(o_rd_ready), 32'd0);
            i_rd_valid = 1'b0;
            pend_rd    = 1'b0;
        end
        if (pend_alu) begin
            m_alu_full = 1'b1;
            m_alu_word = pend_alu_word;
            check("alu_ready_drop", 32'(o_alu_ready), 32'd0);
            i_alu_valid = 1'b0;
            pend_alu    = 1'b0;
        end
        if (!i_rd_valid && rd_q.size() > 0 && (gap_max == 0 || $urandom_range(0, gap_max) == 0)) begin
            i_rd_valid = 1'b1;
            i_rd_data  = rd_q.pop_front();
        end
        if (!i_alu_valid && alu_q.size() > 0 &&
            (gap_max == 0 || $urandom_range(0, gap_max) == 0)) begin
            i_alu_valid = 1'b1;
            i_alu_data  = alu_q.pop_front();
        end
        respond();
        pend_rd       = i_rd_valid && o_rd_ready;
        pend_rd_byte  = i_rd_data;
        pend_alu      = i_alu_valid && o_alu_ready;
        pend_alu_word = i_alu_data;
    endtask

    function automatic bit is_idle();
        return rd_q.size() == 0 && alu_q.size() == 0 && !i_rd_valid && !i_alu_valid &&
               !pend_rd && !pend_alu && !m_rd_full && !m_alu_full && frame_q.size() == 0 &&
               resp_phase == 0 && !retry_exp && !o_active && o_rd_ready && o_alu_ready;
    endfunction

    task automatic run_idle(input int budget);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!is_idle() && n < budget);
        if (!is_idle()) check("idle_budget", 32'(n), 32'(budget + 1));
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST         = 1'b0;
        i_busy      = 1'b0;
        i_rd_valid  = 1'b0;
        i_alu_valid = 1'b0;
        rd_q.delete();
        alu_q.delete();
        frame_q.delete();
        pend_rd    = 1'b0;
        pend_alu   = 1'b0;
        m_rd_full  = 1'b0;
        m_alu_full = 1'b0;
        m_last_alu = 1'b1;
        retry_exp  = 1'b0;
        resp_phase = 0;
        #1;
        check("rst_tx_valid", 32'(o_tx_valid), 32'd0);
        check("rst_tx_data", 32'(o_tx_data), 32'd0);
        check("rst_active", 32'(o_active), 32'd0);
        check("rst_timeout", 32'(o_timeout), 32'd0);
        check("rst_rd_ready", 32'(o_rd_ready), 32'd1);
        check("rst_alu_ready", 32'(o_alu_ready), 32'd1);
        repeat (2) @(negedge CLK);
        RST            = 1'b1;
        prev_valid     = o_tx_valid;
        prev_rd_ready  = o_rd_ready;
        prev_alu_ready = o_alu_ready;
    endtask

    task automatic check_log(input string tag, input int n, input logic [7:0] e0,
                             input logic [7:0] e1, input logic [7:0] e2);
        logic [7:0] e[3];
        e[0] = e0;
        e[1] = e1;
        e[2] = e2;
        check({tag, "_count"}, log_q.size(), n);
        for (int i = 0; i < n && i < log_q.size(); i++) begin
            check(tag, 32'(log_q[i]), 32'(e[i]));
        end
    endtask

    initial begin
        int  n_exp;
        bit  reached;

        do_reset();

        // Tie straight after reset: RD wins first.
        fix_mode = 1'b1; fix_w = 1; fix_b = 2; gap_max = 0;
        log_q.delete();
        rd_q.push_back(8'h11);
        alu_q.push_back(16'hBEEF);
        run_idle(200);
        check_log("tie1", 3, 8'h11, 8'hEF, 8'hBE);

        // RD only, busy raised 3 cycles into the request and held 10 cycles.
        log_q.delete(); fix_w = 2; fix_b = 10; n_timeouts = 0;
        rd_q.push_back(8'hA5);
        run_idle(200);
        check_log("rd_only", 1, 8'hA5, 8'h00, 8'h00);
        check("rd_latency", frame_rise_cyc - rd_acc_cyc, 1);
        check("rd_no_timeout", n_timeouts, 0);

        // Last grant was RD, so ALU wins this tie.
        log_q.delete(); fix_w = 0; fix_b = 1;
        rd_q.push_back(8'h22);
        alu_q.push_back(16'hCAFE);
        run_idle(200);
        check_log("tie2", 3, 8'hFE, 8'hCA, 8'h22);

        // ALU only: LSB then MSB, each with its own request.
        log_q.delete(); fix_w = 1; fix_b = 3;
        alu_q.push_back(16'h1234);
        run_idle(200);
        check_log("alu_only", 2, 8'h34, 8'h12, 8'h00);

        // One timeout, then normal completion with the same byte.
        log_q.delete(); fix_to_left = 1; fix_w = 0; fix_b = 2; n_timeouts = 0;
        rd_q.push_back(8'h3C);
        run_idle(200);
        check_log("timeout", 1, 8'h3C, 8'h00, 8'h00);
        check("timeout_count", n_timeouts, 1);

        // Backpressure: second byte held on the input until the buffer frees.
        log_q.delete(); fix_w = 1; fix_b = 2; n_rd_acc = 0;
        rd_q.push_back(8'h61);
        rd_q.push_back(8'h62);
        run_idle(300);
        check_log("backpressure", 2, 8'h61, 8'h62, 8'h00);
        check("backpressure_accepts", n_rd_acc, 2);

        // Reset while draining the ALU LSB; the MSB must never appear.
        log_q.delete(); fix_w = 0; fix_b = 4; reached = 1'b0;
        alu_q.push_back(16'h1234);
        for (int i = 0; i < 60 && !reached; i++) begin
            cycle();
            if (log_q.size() == 1 && !o_tx_valid && o_active && i_busy) reached = 1'b1;
        end
        check("midframe_reached", 32'(reached), 32'd1);
        do_reset();
        log_q.delete(); fix_b = 2;
        rd_q.push_back(8'h5A);
        run_idle(200);
        check_log("after_reset", 1, 8'h5A, 8'h00, 8'h00);

        // Randomized mixed traffic with random busy timing and occasional timeouts.
        log_q.delete(); fix_mode = 1'b0; gap_max = 3; n_exp = 0;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                rd_q.push_back(8'($urandom));
                n_exp += 1;
            end else begin
                alu_q.push_back(16'($urandom));
                n_exp += 2;
            end
        end
        run_idle(30000);
        check("random_bytes", log_q.size(), n_exp);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
